mux_select_sequencer: RTL and testbench



---
 rtl/mux_select_sequencer_pkg.sv | 33 +++
 rtl/mux_select_sequencer_next_channel_finder.sv | 36 +++
 rtl/mux_select_sequencer.sv | 159 +++++++++++++++
 tb/tb_mux_select_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_select_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// mux_select_sequencer_pkg: shared constants, state type and select mapping
// Revision 1.0
// ============================================================================
package mux_select_sequencer_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    typedef struct packed {
        logic x;
        logic y;
        logic z;
    } xyz_t;

    // x carries the channel index MSB, z the LSB
    function automatic xyz_t idx_to_xyz(input logic [SEL_W-1:0] idx);
        xyz_t s;
        s.x = idx[2];
        s.y = idx[1];
        s.z = idx[0];
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_select_sequencer_next_channel_finder.sv
`default_nettype none
// ============================================================================
// next_channel_finder: next higher enabled index and lowest enabled index
// Revision 1.0
// ============================================================================
module next_channel_finder
    import mux_select_sequencer_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur_idx,
    output logic [SEL_W-1:0]  next_idx,
    output logic              none,
    output logic [SEL_W-1:0]  lowest_idx,
    output logic              mask_empty
);

    // Scan high to low so the last hit is the smallest qualifying index
    always_comb begin
        next_idx   = '0;
        none       = 1'b1;
        lowest_idx = '0;
        mask_empty = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_idx = SEL_W'(i);
                mask_empty = 1'b0;
                if (i > int'(cur_idx)) begin
                    next_idx = SEL_W'(i);
                    none     = 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_select_sequencer.sv
`default_nettype none
// ============================================================================
// mux_select_sequencer: walks an enable mask and drives {x,y,z} mux selects
// Revision 1.0
// ============================================================================
module mux_select_sequencer #(
    parameter int DWELL_W = 8,
    parameter int NUM_CH  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [NUM_CH-1:0]  enable_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               x,
    output logic               y,
    output logic               z,
    output logic               sel_valid,
    output logic               busy,
    output logic               pass_done,
    output logic               done
);
    import mux_select_sequencer_pkg::*;

    if (NUM_CH != mux_select_sequencer_pkg::NUM_CH) begin : g_num_ch_check
        $error("mux_select_sequencer: NUM_CH must be 8 for a 3-bit select");
    end

    state_t             r_state, w_state;
    logic [SEL_W-1:0]   r_idx, w_idx;
    logic [DWELL_W-1:0] r_cnt, w_cnt;
    logic [DWELL_W-1:0] r_dwell, w_dwell;
    logic [NUM_CH-1:0]  r_mask, w_mask;
    logic               r_cont, w_cont;
    logic               w_sel_valid, w_pass_done, w_done;

    logic [SEL_W-1:0]   w_next_idx, w_live_low;
    logic               w_none, w_live_empty;
    logic [SEL_W-1:0]   unused_cap_low, unused_live_next;
    logic               unused_cap_empty, unused_live_none;
    logic               unused_ok;

    // Stepping uses the captured mask; (re)starts use the live inputs
    next_channel_finder u_cap_finder (
        .mask       (r_mask),
        .cur_idx    (r_idx),
        .next_idx   (w_next_idx),
        .none       (w_none),
        .lowest_idx (unused_cap_low),
        .mask_empty (unused_cap_empty)
    );

    next_channel_finder u_live_finder (
        .mask       (enable_mask),
        .cur_idx    ({SEL_W{1'b0}}),
        .next_idx   (unused_live_next),
        .none       (unused_live_none),
        .lowest_idx (w_live_low),
        .mask_empty (w_live_empty)
    );

    assign unused_ok = ^{unused_cap_low, unused_cap_empty, unused_live_next, unused_live_none};

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_cnt       = r_cnt;
        w_dwell     = r_dwell;
        w_mask      = r_mask;
        w_cont      = r_cont;
        w_sel_valid = 1'b0;
        w_pass_done = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_mask  = enable_mask;
                    w_dwell = dwell;
                    w_cont  = continuous;
                    if (!w_live_empty) begin
                        w_state     = ST_SCAN;
                        w_idx       = w_live_low;
                        w_cnt       = dwell;
                        w_sel_valid = 1'b1;
                    end else begin
                        w_state = ST_FINISH;
                    end
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    w_state = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt       = r_cnt - 1'b1;
                    w_sel_valid = 1'b1;
                end else if (!w_none) begin
                    w_idx       = w_next_idx;
                    w_cnt       = r_dwell;
                    w_sel_valid = 1'b1;
                end else begin
                    // Pass boundary: continuous mode re-samples and restarts gap-free
                    w_pass_done = 1'b1;
                    if (r_cont) begin
                        w_mask  = enable_mask;
                        w_dwell = dwell;
                        w_cont  = continuous;
                        if (!w_live_empty) begin
                            w_idx       = w_live_low;
                            w_cnt       = dwell;
                            w_sel_valid = 1'b1;
                        end else begin
                            w_state = ST_FINISH;
                        end
                    end else begin
                        w_state = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                w_state = ST_IDLE;
                w_done  = !stop;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_dwell   <= '0;
            r_mask    <= '0;
            r_cont    <= 1'b0;
            sel_valid <= 1'b0;
            pass_done <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_idx     <= w_idx;
            r_cnt     <= w_cnt;
            r_dwell   <= w_dwell;
            r_mask    <= w_mask;
            r_cont    <= w_cont;
            sel_valid <= w_sel_valid;
            pass_done <= w_pass_done;
            done      <= w_done;
        end
    end

    assign {x, y, z} = idx_to_xyz(r_idx);
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_select_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mux_select_sequencer: vector tables, corner sequences, random scans
// Revision 1.0
// ============================================================================
module tb_mux_select_sequencer;

    typedef struct {
        logic       start;
        logic       stop;
        logic       cont;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic [2:0] xyz;
        logic       v;
        logic       b;
        logic       pd;
        logic       dn;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start, stop, continuous;
    logic [7:0] enable_mask, dwell;
    logic       x, y, z, sel_valid, busy, pass_done, done;

    int         total = 0;
    int         bad = 0;
    vec_t       q[$];
    vec_t       nx;
    logic [2:0] last_xyz;

    always #5 clk = ~clk;

    mux_select_sequencer #(.DWELL_W(8), .NUM_CH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .enable_mask (enable_mask),
        .dwell       (dwell),
        .x           (x),
        .y           (y),
        .z           (z),
        .sel_valid   (sel_valid),
        .busy        (busy),
        .pass_done   (pass_done),
        .done        (done)
    );

    task automatic compare(input string name, input int idx, input logic [6:0] want);
        logic [6:0] got;
        got = {x, y, z, sel_valid, busy, pass_done, done};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] xyz_valid_busy_pd_done got=%b want=%b", name, idx, got, want);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic ct, input logic [7:0] m,
                       input logic [7:0] d, input logic [2:0] xyz, input logic v,
                       input logic b, input logic pd, input logic dn);
        vec_t e;
        e.start = st; e.stop = sp; e.cont = ct; e.mask = m; e.dwell = d;
        e.xyz = xyz; e.v = v; e.b = b; e.pd = pd; e.dn = dn;
        q.push_back(e);
    endtask

    task automatic run_q(input string name);
        for (int i = 0; i < q.size(); i++) begin
            start       = q[i].start;
            stop        = q[i].stop;
            continuous  = q[i].cont;
            enable_mask = q[i].mask;
            dwell       = q[i].dwell;
            @(posedge clk);
            #1;
            compare(name, i, {q[i].xyz, q[i].v, q[i].b, q[i].pd, q[i].dn});
        end
        q.delete();
    endtask

    // Inputs that must be ignored: start while busy, unsampled config
    function automatic vec_t junk();
        vec_t e;
        e.start = 1'($urandom_range(0, 1));
        e.stop  = 1'b0;
        e.cont  = 1'($urandom_range(0, 1));
        e.mask  = 8'($urandom);
        e.dwell = 8'($urandom);
        e.xyz = 3'd0; e.v = 1'b0; e.b = 1'b0; e.pd = 1'b0; e.dn = 1'b0;
        return e;
    endfunction

    task automatic emit(input logic [2:0] xyz, input logic v, input logic b,
                        input logic pd, input logic dn);
        nx.xyz = xyz; nx.v = v; nx.b = b; nx.pd = pd; nx.dn = dn;
        q.push_back(nx);
        nx = junk();
    endtask

    // Reference: each pass presents its enabled channels in ascending order, dwell+1 cycles each
    task automatic build_random();
        logic [7:0] m[4];
        logic [7:0] d[4];
        logic       c[4];
        int         npass, p;
        logic       pdf;
        bit         fin;
        npass = $urandom_range(1, 3);
        for (int i = 0; i < 4; i++) begin
            m[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            d[i] = 8'($urandom_range(0, 3));
            c[i] = (i < npass - 1);
        end
        nx = junk();
        nx.start = 1'b1; nx.mask = m[0]; nx.dwell = d[0]; nx.cont = c[0];
        p = 0; pdf = 1'b0; fin = 1'b0;
        while (!fin) begin
            if (m[p] == 8'h00) begin
                emit(last_xyz, 1'b0, 1'b1, pdf, 1'b0);
                emit(last_xyz, 1'b0, 1'b0, 1'b0, 1'b1);
                fin = 1'b1;
            end else begin
                for (int ch = 0; ch < 8; ch++) begin
                    if (m[p][ch]) begin
                        for (int k = 0; k <= int'(d[p]); k++) begin
                            emit(3'(ch), 1'b1, 1'b1, pdf, 1'b0);
                            pdf = 1'b0;
                            last_xyz = 3'(ch);
                        end
                    end
                end
                if (c[p]) begin
                    p++;
                    nx.mask = m[p]; nx.dwell = d[p]; nx.cont = c[p];
                    pdf = 1'b1;
                end else begin
                    emit(last_xyz, 1'b0, 1'b1, 1'b1, 1'b0);
                    emit(last_xyz, 1'b0, 1'b0, 1'b0, 1'b1);
                    fin = 1'b1;
                end
            end
        end
        nx.start = 1'b0;
        emit(last_xyz, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        start = 1'b1; stop = 1'b0; continuous = 1'b0; enable_mask = 8'hFF; dwell = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        compare("reset_hold", 0, 7'b000_0_0_0_0);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        compare("reset_release", 0, 7'b000_0_0_0_0);

        // Basic one-shot over channels 1 and 2, dwell 1
        add(1, 0, 0, 8'h06, 8'd1, 3'b001, 1, 1, 0, 0);
        add(0, 0, 0, 8'h06, 8'd1, 3'b001, 1, 1, 0, 0);
        add(0, 0, 0, 8'h06, 8'd1, 3'b010, 1, 1, 0, 0);
        add(0, 0, 0, 8'h06, 8'd1, 3'b010, 1, 1, 0, 0);
        add(0, 0, 0, 8'h06, 8'd1, 3'b010, 0, 1, 1, 0);
        add(0, 0, 0, 8'h06, 8'd1, 3'b010, 0, 0, 0, 1);
        add(0, 0, 0, 8'h06, 8'd1, 3'b010, 0, 0, 0, 0);
        run_q("oneshot");

        add(1, 0, 0, 8'h00, 8'd1, 3'b010, 0, 1, 0, 0);
        add(0, 0, 0, 8'h00, 8'd1, 3'b010, 0, 0, 0, 1);
        add(0, 0, 0, 8'h00, 8'd1, 3'b010, 0, 0, 0, 0);
        run_q("empty_mask");

        // Continuous, mask change mid-pass, then leave continuous mode
        add(1, 0, 1, 8'h81, 8'd0, 3'b000, 1, 1, 0, 0);
        add(0, 0, 1, 8'h81, 8'd0, 3'b111, 1, 1, 0, 0);
        add(0, 0, 1, 8'h81, 8'd0, 3'b000, 1, 1, 1, 0);
        add(0, 0, 1, 8'h10, 8'd0, 3'b111, 1, 1, 0, 0);
        add(0, 0, 1, 8'h10, 8'd0, 3'b100, 1, 1, 1, 0);
        add(0, 0, 1, 8'h10, 8'd0, 3'b100, 1, 1, 1, 0);
        add(0, 0, 1, 8'h10, 8'd0, 3'b100, 1, 1, 1, 0);
        add(0, 0, 0, 8'h10, 8'd0, 3'b100, 1, 1, 1, 0);
        add(0, 0, 0, 8'h10, 8'd0, 3'b100, 0, 1, 1, 0);
        add(0, 0, 0, 8'h10, 8'd0, 3'b100, 0, 0, 0, 1);
        add(0, 0, 0, 8'h10, 8'd0, 3'b100, 0, 0, 0, 0);
        run_q("continuous");

        // Stop during channel 3, then start+stop in idle, then stop in FINISH
        for (int i = 0; i < 14; i++)
            add(i == 0, 0, 0, 8'hFF, 8'd3, 3'(i / 4), 1, 1, 0, 0);
        add(0, 1, 0, 8'hFF, 8'd3, 3'b011, 0, 0, 0, 0);
        add(1, 1, 0, 8'hFF, 8'd3, 3'b011, 0, 0, 0, 0);
        add(0, 0, 0, 8'hFF, 8'd3, 3'b011, 0, 0, 0, 0);
        add(1, 0, 0, 8'h00, 8'd3, 3'b011, 0, 1, 0, 0);
        add(0, 1, 0, 8'h00, 8'd3, 3'b011, 0, 0, 0, 0);
        add(0, 0, 0, 8'h00, 8'd3, 3'b011, 0, 0, 0, 0);
        run_q("stop");

        // Asynchronous reset between edges, then an immediate restart
        add(1, 0, 0, 8'h0C, 8'd2, 3'b010, 1, 1, 0, 0);
        add(0, 0, 0, 8'h0C, 8'd2, 3'b010, 1, 1, 0, 0);
        run_q("pre_async");
        #3 rst_n = 1'b0;
        #1 compare("async_reset", 0, 7'b000_0_0_0_0);
        #1 rst_n = 1'b1;
        add(1, 0, 0, 8'h0C, 8'd0, 3'b010, 1, 1, 0, 0);
        add(0, 0, 0, 8'h0C, 8'd0, 3'b011, 1, 1, 0, 0);
        add(0, 0, 0, 8'h0C, 8'd0, 3'b011, 0, 1, 1, 0);
        add(0, 0, 0, 8'h0C, 8'd0, 3'b011, 0, 0, 0, 1);
        add(0, 0, 0, 8'h0C, 8'd0, 3'b011, 0, 0, 0, 0);
        run_q("post_async");

        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_xyz = 3'b000;
        for (int n = 0; n < 40; n++) begin
            build_random();
            run_q("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
